// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end: 2-FF sync, per-channel glitch filter, Gray decode into step/dir pulses.
// Latency: pin change sampled at edge k -> filtered at k+1+FILT_LEN -> pulse registered at k+2+FILT_LEN.
// No backpressure: step_en/err_pulse are single-cycle strobes the counter must accept every cycle.
module quad_step_decoder #(
   parameter int FILT_LEN = 4,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_in,
   input  logic             b_in,
   input  logic             en,
   input  logic             clr_err,
   output logic             step_en,
   output logic             step_up,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_cnt,
   output logic [1:0]       ab_filt,
   output logic             locked
);

   localparam int            CW      = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   // Channel pairs are always packed {A,B}: bit 1 is A, bit 0 is B.
   logic [1:0]          s1_q, s2_q;
   logic [1:0]          sync_vld_q;
   logic [1:0][CW-1:0]  cnt_q, cnt_d;
   logic [CW-1:0]       init_cnt_q, init_cnt_d;
   logic [1:0]          filt_q, filt_d;
   logic [1:0]          prev_q, prev_d;
   state_t              state_q, state_d;
   logic                step_en_q, step_en_d;
   logic                step_up_q, step_up_d;
   logic                err_pulse_q, err_pulse_d;
   logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
   logic [1:0]          diff;

   // Next-state: initial capture, per-channel filtering and transition decode.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_cnt_d  = init_cnt_q;
      filt_d      = filt_q;
      prev_d      = prev_q;
      step_en_d   = 1'b0;
      step_up_d   = step_up_q;
      err_pulse_d = 1'b0;
      err_cnt_d   = err_cnt_q;
      diff        = 2'b00;

      case (state_q)
         ST_INIT: begin
            cnt_d = '0;
            // s1==s2 means s2 holds its value across this edge; only trusted once
            // the sync chain has been refilled from the pins after reset.
            if (sync_vld_q[1] && (s1_q == s2_q)) begin
               if (init_cnt_q == CNT_MAX) begin
                  filt_d     = s2_q;
                  prev_d     = s2_q;
                  init_cnt_d = '0;
                  state_d    = ST_RUN;
               end else begin
                  init_cnt_d = init_cnt_q + 1'b1;
               end
            end else begin
               init_cnt_d = '0;
            end
         end

         ST_RUN: begin
            for (int ch = 0; ch < 2; ch++) begin
               if (s2_q[ch] != filt_q[ch]) begin
                  if (cnt_q[ch] == CNT_MAX) begin
                     filt_d[ch] = s2_q[ch];
                     cnt_d[ch]  = '0;
                  end else begin
                     cnt_d[ch] = cnt_q[ch] + 1'b1;
                  end
               end else begin
                  cnt_d[ch] = '0;
               end
            end

            // prev tracks unconditionally so re-enabling never replays old motion.
            diff   = filt_q ^ prev_q;
            prev_d = filt_q;
            if (en) begin
               if (diff == 2'b11) begin
                  err_pulse_d = 1'b1;
                  if (err_cnt_q != '1) begin
                     err_cnt_d = err_cnt_q + 1'b1;
                  end
               end else if (diff != 2'b00) begin
                  // Forward sequence 00->01->11->10 always lands with new A equal to old B.
                  step_en_d = 1'b1;
                  step_up_d = (filt_q[1] == prev_q[0]);
               end
            end
         end

         default: state_d = ST_INIT;
      endcase

      if (clr_err) begin
         err_cnt_d = '0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q        <= 2'b00;
         s2_q        <= 2'b00;
         sync_vld_q  <= 2'b00;
         cnt_q       <= '0;
         init_cnt_q  <= '0;
         filt_q      <= 2'b00;
         prev_q      <= 2'b00;
         state_q     <= ST_INIT;
         step_en_q   <= 1'b0;
         step_up_q   <= 1'b0;
         err_pulse_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         s1_q        <= {a_in, b_in};
         s2_q        <= s1_q;
         sync_vld_q  <= {sync_vld_q[0], 1'b1};
         cnt_q       <= cnt_d;
         init_cnt_q  <= init_cnt_d;
         filt_q      <= filt_d;
         prev_q      <= prev_d;
         state_q     <= state_d;
         step_en_q   <= step_en_d;
         step_up_q   <= step_up_d;
         err_pulse_q <= err_pulse_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign step_en   = step_en_q;
   assign step_up   = step_up_q;
   assign err_pulse = err_pulse_q;
   assign err_cnt   = err_cnt_q;
   assign ab_filt   = filt_q;
   assign locked    = (state_q == ST_RUN);

endmodule
